// File: rtl/seq_adder_mp.sv
// rtl/seq_adder_mp.sv - multi-cycle multi-precision adder built on one 5-bit slice
//
// adder5: 5-bit ripple adder slice.
//   a, b  in  5   slice operands
//   ci    in  1   carry in
//   s     out 5   slice sum
//   co    out 1   slice carry out
//
// seq_adder_mp: walks W = 5*SLICES bit operands through a single adder5,
// low slice first, one slice per clock, carrying through a register.
//   clk       in  1  clock, rising edge
//   rst       in  1  asynchronous active-high reset
//   InValid   in  1  producer offers A/B/Cin
//   InReady   out 1  operands accepted (IDLE only)
//   A, B      in  W  operands, sampled on input handshake
//   Cin       in  1  carry into slice 0, sampled on input handshake
//   OutValid  out 1  Sum/Cout/Overflow hold a new result (DONE only)
//   OutReady  in  1  consumer takes the result
//   Sum       out W  registered sum modulo 2^W
//   Cout      out 1  registered unsigned carry out
//   Overflow  out 1  registered two's-complement overflow

module adder5 (
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic       ci,
    output logic [4:0] s,
    output logic       co
);
    logic [5:0] w_full;

    assign w_full = {1'b0, a} + {1'b0, b} + {5'd0, ci};
    assign s      = w_full[4:0];
    assign co     = w_full[5];
endmodule

module seq_adder_mp #(
    parameter int SLICES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                InValid,
    output logic                InReady,
    input  logic [5*SLICES-1:0] A,
    input  logic [5*SLICES-1:0] B,
    input  logic                Cin,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [5*SLICES-1:0] Sum,
    output logic                Cout,
    output logic                Overflow
);
    localparam int W    = 5 * SLICES;
    localparam int IDXW = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(SLICES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_c;
    logic [IDXW-1:0] r_idx;
    logic [W-1:0]    r_p;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;

    logic [4:0]      w_slice_a;
    logic [4:0]      w_slice_b;
    logic [4:0]      w_slice_s;
    logic            w_slice_co;
    logic [W-1:0]    w_p_merged;
    logic            w_last;
    logic            w_accept;

    // Slice mux: the only path into the shared adder, so the critical path
    // stays one 5-bit ripple regardless of SLICES.
    assign w_slice_a = r_a[5*r_idx +: 5];
    assign w_slice_b = r_b[5*r_idx +: 5];

    adder5 u_adder5 (
        .a  (w_slice_a),
        .b  (w_slice_b),
        .ci (r_c),
        .s  (w_slice_s),
        .co (w_slice_co)
    );

    // Partial sum with the current slice dropped in; on the last slice this
    // is the complete sum, loaded straight into the result register.
    always_comb begin
        w_p_merged = r_p;
        w_p_merged[5*r_idx +: 5] = w_slice_s;
    end

    assign w_last   = (r_idx == LAST_IDX);
    assign w_accept = (r_state == S_IDLE) && InValid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        InReady      = 1'b0;
        OutValid     = 1'b0;
        case (r_state)
            S_IDLE: begin
                InReady = 1'b1;
                if (InValid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                OutValid = 1'b1;
                if (OutReady) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_c    <= 1'b0;
            r_idx  <= '0;
            r_p    <= '0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_c   <= Cin;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_p   <= w_p_merged;
            r_c   <= w_slice_co;
            r_idx <= r_idx + IDXW'(1);
            if (w_last) begin
                r_sum  <= w_p_merged;
                r_cout <= w_slice_co;
                // Signed overflow: like-signed operands producing a result of
                // the other sign. Cin does not alter the rule.
                r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_p_merged[W-1] != r_a[W-1]);
            end
        end
    end

    assign Sum      = r_sum;
    assign Cout     = r_cout;
    assign Overflow = r_ovf;
endmodule

// File: tb/tb_seq_adder_mp.sv
// tb/tb_seq_adder_mp.sv - table-driven scoreboard bench for seq_adder_mp
module tb_seq_adder_mp;
    localparam int SLICES = 2;
    localparam int W      = 5 * SLICES;
    localparam int NV     = 7;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         InValid = 1'b0;
    logic         InReady;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         OutValid;
    logic         OutReady = 1'b0;
    logic [W-1:0] Sum;
    logic         Cout;
    logic         Overflow;

    seq_adder_mp #(.SLICES(SLICES)) dut (
        .clk      (clk),
        .rst      (rst),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Sum      (Sum),
        .Cout     (Cout),
        .Overflow (Overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        res_t         exp;
    } vec_t;

    res_t sb[$];
    vec_t vecs[NV];

    int checks   = 0;
    int failures = 0;
    int acc_cnt  = 0;

    always @(posedge clk) begin
        if (!rst && InValid && InReady) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk_w(string name, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_b(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_i(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic cin);
        logic [W:0] t;
        res_t r;
        t      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
        return r;
    endfunction

    // Offers operands, waits (bounded) for InReady, completes the handshake
    // and returns at the negedge right after the accepting edge.
    task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic cin, res_t exp);
        int n;
        @(negedge clk);
        InValid = 1'b1;
        A = a;
        B = b;
        Cin = cin;
        n = 0;
        while (!InReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk_b("send_timeout", InReady, 1'b1);
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        InValid = 1'b0;
    endtask

    // Called at the negedge after acceptance; measures latency and compares
    // the result against the scoreboard head.
    task automatic wait_result(string tag);
        int lat;
        res_t e;
        lat = 0;
        while (!OutValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk_i({tag, "_latency"}, lat, SLICES);
        if (sb.size() == 0) begin
            chk_i({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk_w({tag, "_sum"}, Sum, e.sum);
            chk_b({tag, "_cout"}, Cout, e.cout);
            chk_b({tag, "_ovf"}, Overflow, e.ovf);
        end
    endtask

    task automatic release_result(string tag);
        OutReady = 1'b1;
        @(negedge clk);
        OutReady = 1'b0;
        chk_b({tag, "_outvalid_drop"}, OutValid, 1'b0);
        chk_b({tag, "_inready_rise"}, InReady, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        logic seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rc;

        vecs[0] = '{a: 10'h3FF, b: 10'h001, cin: 1'b0, exp: '{sum: 10'h000, cout: 1'b1, ovf: 1'b0}};
        vecs[1] = '{a: 10'h1FF, b: 10'h001, cin: 1'b0, exp: '{sum: 10'h200, cout: 1'b0, ovf: 1'b1}};
        vecs[2] = '{a: 10'h200, b: 10'h200, cin: 1'b0, exp: '{sum: 10'h000, cout: 1'b1, ovf: 1'b1}};
        vecs[3] = '{a: 10'h01F, b: 10'h001, cin: 1'b0, exp: '{sum: 10'h020, cout: 1'b0, ovf: 1'b0}};
        vecs[4] = '{a: 10'h000, b: 10'h000, cin: 1'b1, exp: '{sum: 10'h001, cout: 1'b0, ovf: 1'b0}};
        vecs[5] = '{a: 10'h3FF, b: 10'h000, cin: 1'b1, exp: '{sum: 10'h000, cout: 1'b1, ovf: 1'b0}};
        vecs[6] = '{a: 10'h2AA, b: 10'h2AA, cin: 1'b1, exp: '{sum: 10'h155, cout: 1'b1, ovf: 1'b1}};

        // Asynchronous reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk_b("rst_inready", InReady, 1'b1);
        chk_b("rst_outvalid", OutValid, 1'b0);
        chk_w("rst_sum", Sum, '0);
        chk_b("rst_cout", Cout, 1'b0);
        chk_b("rst_ovf", Overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);
            wait_result($sformatf("vec%0d", i));
            release_result($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            send(ra, rb, rc, model(ra, rb, rc));
            wait_result($sformatf("rnd%0d", i));
            release_result($sformatf("rnd%0d", i));
        end

        // Backpressure: result held in DONE while new operands are offered.
        send(10'h155, 10'h0AA, 1'b0, '{sum: 10'h1FF, cout: 1'b0, ovf: 1'b0});
        wait_result("bp");
        @(negedge clk);
        InValid = 1'b1;
        A = 10'h001;
        B = 10'h002;
        Cin = 1'b0;
        base = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_w("bp_sum_hold", Sum, 10'h1FF);
            chk_b("bp_outvalid_hold", OutValid, 1'b1);
            chk_b("bp_inready_low", InReady, 1'b0);
        end
        chk_i("bp_not_taken", acc_cnt, base);
        OutReady = 1'b1;
        @(negedge clk);
        OutReady = 1'b0;
        chk_b("bp_inready_after", InReady, 1'b1);
        sb.push_back('{sum: 10'h003, cout: 1'b0, ovf: 1'b0});
        @(posedge clk);
        @(negedge clk);
        InValid = 1'b0;
        chk_i("bp_taken_once", acc_cnt, base + 1);
        wait_result("bp_new");
        release_result("bp_new");
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk_b("bp_no_second_result", OutValid, 1'b0);
        chk_i("bp_still_once", acc_cnt, base + 1);

        // Asynchronous reset while a result is held in DONE.
        send(10'h155, 10'h0AA, 1'b0, '{sum: 10'h1FF, cout: 1'b0, ovf: 1'b0});
        wait_result("done_rst_pre");
        #2 rst = 1'b1;
        #1;
        chk_b("done_rst_inready", InReady, 1'b1);
        chk_b("done_rst_outvalid", OutValid, 1'b0);
        chk_w("done_rst_sum", Sum, '0);
        @(negedge clk);
        rst = 1'b0;

        // Reset one cycle into RUN aborts the operation.
        send(10'h3FF, 10'h3FF, 1'b0, model(10'h3FF, 10'h3FF, 1'b0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (OutValid) seen = 1'b1;
        end
        chk_b("abort_no_outvalid", seen, 1'b0);
        chk_w("abort_sum", Sum, '0);
        chk_b("abort_cout", Cout, 1'b0);
        chk_b("abort_ovf", Overflow, 1'b0);
        send(10'h005, 10'h003, 1'b0, '{sum: 10'h008, cout: 1'b0, ovf: 1'b0});
        wait_result("after_abort");
        release_result("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
